// File: rtl/serial_add_seq.sv
// Bit-serial add/subtract sequencer: one full-adder cell (two half adders + OR)
// reused LSB-first across WIDTH bits, with a start/ready/done handshake.

module half_adder (
  input  logic a_i,
  input  logic b_i,
  output logic s_o,
  output logic c_o
);
  assign s_o = a_i ^ b_i;
  assign c_o = a_i & b_i;
endmodule

module serial_fa_cell (
  input  logic a_i,
  input  logic b_i,
  input  logic c_i,
  output logic s_o,
  output logic c_o
);
  logic s0, c0, c1;

  half_adder u_ha0 (.a_i(a_i), .b_i(b_i), .s_o(s0),  .c_o(c0));
  half_adder u_ha1 (.a_i(s0),  .b_i(c_i), .s_o(s_o), .c_o(c1));

  assign c_o = c0 | c1;
endmodule

// state | meaning
// IDLE  | ready, waiting for start; captures operands on accept
// RUN   | one bit per cycle through the shared cell, LSB first
// DONE  | one-cycle result-valid pulse, then back to IDLE
module serial_add_seq #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             ready,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout
);
  localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] sa_q, sa_d;
  logic [WIDTH-1:0] sb_q, sb_d;
  logic [WIDTH-1:0] r_q, r_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  logic fa_s, fa_co;

  serial_fa_cell u_cell (
    .a_i(sa_q[0]),
    .b_i(sb_q[0]),
    .c_i(carry_q),
    .s_o(fa_s),
    .c_o(fa_co)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      sa_q    <= '0;
      sb_q    <= '0;
      r_q     <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      sa_q    <= sa_d;
      sb_q    <= sb_d;
      r_q     <= r_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sa_d    = sa_q;
    sb_d    = sb_q;
    r_d     = r_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;

    case (state_q)
      IDLE: begin
        if (start) begin
          // subtraction is a + ~b + 1: invert B here, inject the +1 as carry-in
          sa_d    = a;
          sb_d    = sub ? ~b : b;
          carry_d = sub;
          cnt_d   = '0;
          state_d = RUN;
        end
      end
      RUN: begin
        carry_d = fa_co;
        sa_d    = sa_q >> 1;
        sb_d    = sb_q >> 1;
        r_d     = {fa_s, r_q[WIDTH-1:1]};
        cnt_d   = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH-1)) begin
          sum_d   = {fa_s, r_q[WIDTH-1:1]};
          cout_d  = fa_co;
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign ready = (state_q == IDLE);
  assign busy  = (state_q == RUN);
  assign done  = (state_q == DONE);
  assign sum   = sum_q;
  assign cout  = cout_q;

endmodule

// File: doc/serial_add_seq.md
Name: serial_add_seq

Overview:
- Bit-serial add/subtract sequencer that time-multiplexes one 1-bit full-adder cell across the bits of two WIDTH-bit operands.
- The cell is built internally from two HalfAdder instances plus an OR for carry-out.
- Intended use in the floating-point adder is the exponent-difference / compare step (a - b, borrow flag), trading one cycle per bit for minimal area.
- Provides a start / ready / done handshake to the FP control path.

Parameters:
- WIDTH, 8, operand and result width in bits; legal range 2..32.

Ports:
- clk  input  1  rising-edge clock
- rst_n  input  1  asynchronous active-low reset
- start  input  1  request; sampled only while ready=1
- sub  input  1  0: sum = a + b; 1: sum = a - b (a + ~b + 1)
- a  input  WIDTH  operand A, captured on accepted start
- b  input  WIDTH  operand B, captured on accepted start
- ready  output  1  block idle, start will be accepted
- busy  output  1  serial operation in progress
- done  output  1  one-cycle pulse, result valid
- sum  output  WIDTH  registered result
- cout  output  1  carry out of MSB; in sub mode 1 = no borrow (a >= b unsigned)

Behaviour:
- Clock and reset: one clock, clk; reset is asynchronous and active-low, rst_n.
- States: IDLE, RUN, DONE.
- ready = (state == IDLE); busy = (state == RUN); done = (state == DONE). All are decoded from registered state.
- Reset (rst_n low, asynchronous, any state): state=IDLE, sum=0, cout=0, bit counter=0, operand shift registers=0, carry register=0. Outputs during reset are ready=1, busy=0, done=0.
- IDLE:
  - On a clock edge with start=1: capture a into shift register SA and (sub ? ~b : b) into SB.
  - Load carry register with sub; clear the counter; go to RUN.
  - start=0: remain in IDLE.
- RUN: each edge processes one bit, LSB first:
  - s = SA[0] ^ SB[0] ^ carry; carry <= majority(SA[0], SB[0], carry).
  - SA and SB shift right by 1.
  - s shifts into the MSB of result shift register R.
  - Counter increments.
  - On the edge where counter == WIDTH-1 (the last bit): sum <= final R value including this bit, cout <= new carry, state <= DONE.
- DONE: one cycle only, then IDLE unconditionally. start is ignored in DONE.
- Timing, with an accepted start in cycle 0:
  - busy is high in cycles 1..WIDTH.
  - done is high in cycle WIDTH+1.
  - ready returns in cycle WIDTH+2.
  - Minimum issue interval is WIDTH+2 cycles.
- sum and cout change only on the RUN-to-DONE edge. They hold their value through IDLE until the next completion; they are not cleared by a new start.
- a, b and sub are don't-care outside the accepting edge. Changes during RUN have no effect.
- start asserted while busy or in DONE is dropped, not queued. The requester must hold start until it sees ready=1 at the sampling edge.
- Arithmetic is unsigned and modulo 2^WIDTH; no overflow flag.
  - Sub mode: cout=1 iff a >= b.
  - Equal operands give sum=0, cout=1.
- Reset mid-RUN aborts immediately: no done pulse is produced and sum/cout go to 0.

Test Plan:
- WIDTH=8, sub=0, a=8'h3C, b=8'h05, start pulsed in cycle 0 -> busy cycles 1-8, done exactly cycle 9, sum=8'h41, cout=0, ready high again cycle 10.
- WIDTH=8, sub=0, a=8'hFF, b=8'h01 -> sum=8'h00, cout=1 (full carry ripple). Then a=8'h80, b=8'h80 -> sum=8'h00, cout=1.
- WIDTH=8, sub=1: 8'h82-8'h7E -> sum=8'h04, cout=1; 8'h7E-8'h82 -> sum=8'hFC, cout=0; 8'h55-8'h55 -> sum=8'h00, cout=1.
- start held high continuously; a/b toggled every cycle during busy -> only the values on accepting edges are used; done pulses every 10 cycles (WIDTH=8); results match those operands; sum is stable between done pulses.
- rst_n driven low asynchronously mid-cycle during cycle 4 of a run -> ready=1, busy=0, sum=0, cout=0 immediately, no done pulse. After release, a new op 8'h10+8'h20 -> sum=8'h30, cout=0.
- WIDTH=24, sub=1, a=24'h000000, b=24'h000001 -> done in cycle 25, sum=24'hFFFFFF, cout=0.
